// File: rtl/ccff_readback_ctrl.sv
// Configuration-chain readback: rotates the chain once through ccff_tail -> ccff_head
// and streams the captured bits out as WORD_W-bit words (first bit in bit 0).
module ccff_readback_ctrl #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              ccff_tail,
  output logic              ccff_head,
  output logic              chain_shift_en,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = $clog2(WORD_W + 1);
  localparam logic [IDX_W-1:0] IDX_FULL  = IDX_W'(WORD_W);
  localparam logic [CNT_W-1:0] BITS_INIT = CNT_W'(CHAIN_LEN);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  bits_left;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] capture;
  logic              cap_full, out_free, xfer;

  // A partial last word counts as full once the chain is exhausted; its upper bits are already zero.
  assign cap_full  = (idx == IDX_FULL) || ((bits_left == '0) && (idx != '0));
  assign out_free  = !rd_valid || rd_ready;
  assign xfer      = cap_full && out_free && ((state == SHIFT) || (state == DRAIN));
  assign ccff_head = busy ? ccff_tail : 1'b0;

  always_comb begin
    state_nxt      = state;
    busy           = 1'b0;
    done           = 1'b0;
    chain_shift_en = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy           = 1'b1;
        chain_shift_en = (bits_left != '0) && (!cap_full || out_free);
        if (bits_left == '0) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if ((idx == '0) && out_free) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (!pReset_n) begin
      state     <= IDLE;
      bits_left <= '0;
      idx       <= '0;
      capture   <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && start) begin
        bits_left <= BITS_INIT;
        idx       <= '0;
        capture   <= '0;
      end
      if (chain_shift_en) bits_left <= bits_left - 1'b1;

      // Word transfer and a fresh capture into bit 0 share the same edge.
      if (xfer) begin
        rd_data  <= capture;
        rd_valid <= 1'b1;
        if (chain_shift_en) begin
          capture <= WORD_W'(ccff_tail);
          idx     <= IDX_W'(1);
        end else begin
          capture <= '0;
          idx     <= '0;
        end
      end else begin
        if (rd_valid && rd_ready) rd_valid <= 1'b0;
        if (chain_shift_en) begin
          for (int i = 0; i < WORD_W; i++) begin
            if (idx == IDX_W'(i)) capture[i] <= ccff_tail;
          end
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ccff_readback_ctrl.sv
// Bench for ccff_readback_ctrl: three instances (20/8, 16/8, 1/2) each driving a
// behavioural chain; words are predicted from a snapshot of the chain at start.
module tb_ccff_readback_ctrl;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic        pReset_n = 1'b0;
  logic        rd_ready = 1'b1;
  logic        start_v  = 1'b0;
  logic        ld       = 1'b0;
  logic [19:0] ld_val   = '0;
  logic [1:0]  sel      = 2'd0;
  int          cur_len  = 20;
  int          cur_w    = 8;

  logic       a_start, a_tail, a_head, a_sen, a_valid, a_busy, a_done;
  logic [7:0] a_data;
  logic       b_start, b_tail, b_head, b_sen, b_valid, b_busy, b_done;
  logic [7:0] b_data;
  logic       c_start, c_tail, c_head, c_sen, c_valid, c_busy, c_done;
  logic [1:0] c_data;

  logic [19:0] chain_a;
  logic [15:0] chain_b;
  logic        chain_c;

  assign a_start = start_v && (sel == 2'd0);
  assign b_start = start_v && (sel == 2'd1);
  assign c_start = start_v && (sel == 2'd2);
  assign a_tail  = chain_a[0];
  assign b_tail  = chain_b[0];
  assign c_tail  = chain_c;

  ccff_readback_ctrl #(.CHAIN_LEN(20), .WORD_W(8), .CNT_W(16)) dut_a (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(a_start), .ccff_tail(a_tail),
    .ccff_head(a_head), .chain_shift_en(a_sen), .rd_data(a_data), .rd_valid(a_valid),
    .rd_ready(rd_ready), .busy(a_busy), .done(a_done));

  ccff_readback_ctrl #(.CHAIN_LEN(16), .WORD_W(8), .CNT_W(16)) dut_b (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(b_start), .ccff_tail(b_tail),
    .ccff_head(b_head), .chain_shift_en(b_sen), .rd_data(b_data), .rd_valid(b_valid),
    .rd_ready(rd_ready), .busy(b_busy), .done(b_done));

  ccff_readback_ctrl #(.CHAIN_LEN(1), .WORD_W(2), .CNT_W(16)) dut_c (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(c_start), .ccff_tail(c_tail),
    .ccff_head(c_head), .chain_shift_en(c_sen), .rd_data(c_data), .rd_valid(c_valid),
    .rd_ready(rd_ready), .busy(c_busy), .done(c_done));

  // Behavioural chains: head enters the far end, bit 0 sits at the tail.
  always @(posedge prog_clk) begin
    if (ld && sel == 2'd0) chain_a <= ld_val;
    else if (a_sen)        chain_a <= {a_head, chain_a[19:1]};
    if (ld && sel == 2'd1) chain_b <= ld_val[15:0];
    else if (b_sen)        chain_b <= {b_head, chain_b[15:1]};
    if (ld && sel == 2'd2) chain_c <= ld_val[0];
    else if (c_sen)        chain_c <= c_head;
  end

  logic        obs_sen, obs_head, obs_valid, obs_busy, obs_done;
  logic [7:0]  obs_data;
  logic [19:0] obs_chain;

  always_comb begin
    obs_sen = a_sen; obs_head = a_head; obs_valid = a_valid; obs_busy = a_busy;
    obs_done = a_done; obs_data = a_data; obs_chain = chain_a;
    case (sel)
      2'd1: begin
        obs_sen = b_sen; obs_head = b_head; obs_valid = b_valid; obs_busy = b_busy;
        obs_done = b_done; obs_data = b_data; obs_chain = {4'b0, chain_b};
      end
      2'd2: begin
        obs_sen = c_sen; obs_head = c_head; obs_valid = c_valid; obs_busy = c_busy;
        obs_done = c_done; obs_data = {6'b0, c_data}; obs_chain = {19'b0, chain_c};
      end
      default: ;
    endcase
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic load(input logic [1:0] s, input int len, input int w, input logic [19:0] v);
    @(posedge prog_clk); #1;
    sel = s; cur_len = len; cur_w = w; ld = 1'b1; ld_val = v;
    @(posedge prog_clk); #1;
    ld = 1'b0;
  endtask

  // One readback on the selected instance; -1 disables an optional feature/check.
  task automatic run(input int stall_lo, input int stall_hi, input int start_cyc, input int rst_cyc,
                     input bit rnd, input int sen0_cyc, input int exp_done, input int exp_fv);
    logic [31:0] snap, mask;
    logic [31:0] exp_w[$];
    int nw, wc, shifts, dones, done_c, fv;
    logic pv, pr;
    logic [7:0] pd;
    @(posedge prog_clk); #1;
    pReset_n = 1'b1; rd_ready = 1'b1; start_v = 1'b1;
    snap = 32'(obs_chain);
    mask = (32'd1 << cur_w) - 32'd1;
    nw = (cur_len + cur_w - 1) / cur_w;
    exp_w.delete();
    for (int k = 0; k < nw; k++) exp_w.push_back((snap >> (k * cur_w)) & mask);
    wc = 0; shifts = 0; dones = 0; done_c = -1; fv = -1; pv = 1'b0; pr = 1'b1; pd = '0;
    #1;
    check("idle_busy", 32'(obs_busy), 32'd0);
    @(posedge prog_clk); #1;
    for (int c = 1; c <= 150; c++) begin
      rd_ready = rnd ? ($urandom_range(0, 3) != 0) : !(c >= stall_lo && c <= stall_hi);
      start_v  = (c == start_cyc);
      pReset_n = (c != rst_cyc);
      #1;
      if (rst_cyc > 0 && c == rst_cyc + 1) begin
        check("rst_busy", 32'(obs_busy), 32'd0);
        check("rst_valid", 32'(obs_valid), 32'd0);
        check("rst_data", 32'(obs_data), 32'd0);
        check("rst_sen", 32'(obs_sen), 32'd0);
        check("rst_head", 32'(obs_head), 32'd0);
        check("rst_done", 32'(obs_done), 32'd0);
        check("rst_shifts", 32'(shifts), 32'(rst_cyc));
        return;
      end
      if (obs_sen) shifts++;
      if (pv && !pr) begin
        check("stall_valid", 32'(obs_valid), 32'd1);
        check("stall_data", 32'(obs_data), 32'(pd));
      end
      if (obs_valid && fv < 0) fv = c;
      if (obs_valid && rd_ready) begin
        if (wc < nw) check("word", 32'(obs_data), exp_w[wc]);
        else check("extra_word", 32'(wc + 1), 32'(nw));
        wc++;
      end
      if (c == sen0_cyc) check("stall_sen", 32'(obs_sen), 32'd0);
      if (done_c >= 0 && c == done_c + 1) begin
        check("done_pulse", 32'(obs_done), 32'd0);
        check("post_busy", 32'(obs_busy), 32'd0);
        break;
      end
      if (obs_done) begin
        dones++;
        done_c = c;
        check("done_busy", 32'(obs_busy), 32'd0);
        check("done_sen", 32'(obs_sen), 32'd0);
      end else if (rst_cyc != c) begin
        check("busy", 32'(obs_busy), 32'd1);
      end
      pv = obs_valid; pr = rd_ready; pd = obs_data;
      @(posedge prog_clk); #1;
    end
    start_v = 1'b0;
    rd_ready = 1'b1;
    check("done_count", 32'(dones), 32'd1);
    check("word_count", 32'(wc), 32'(nw));
    check("shift_count", 32'(shifts), 32'(cur_len));
    check("chain_kept", 32'(obs_chain), snap);
    if (exp_done >= 0) check("done_cycle", 32'(done_c), 32'(exp_done));
    if (exp_fv >= 0) check("first_valid", 32'(fv), 32'(exp_fv));
  endtask

  initial begin
    pReset_n = 1'b0;
    repeat (2) @(posedge prog_clk);
    #1;
    check("reset_a_valid", 32'(a_valid), 32'd0);
    check("reset_a_data", 32'(a_data), 32'd0);
    check("reset_a_busy", 32'(a_busy), 32'd0);
    check("reset_a_done", 32'(a_done), 32'd0);
    check("reset_a_sen", 32'(a_sen), 32'd0);
    check("reset_a_head", 32'(a_head), 32'd0);
    check("reset_c_valid", 32'(c_valid), 32'd0);
    pReset_n = 1'b1;

    // Basic, backpressure, ignored start, reset mid-readback then recovery.
    load(2'd0, 20, 8, 20'hA5C3F);
    run(-1, -1, -1, -1, 1'b0, -1, 23, 10);
    run(10, 17, -1, -1, 1'b0, 17, 24, 10);
    run(-1, -1, 5, -1, 1'b0, -1, 23, 10);
    run(-1, -1, -1, 7, 1'b0, -1, -1, -1);
    run(-1, -1, -1, -1, 1'b0, -1, 23, 10);

    // Exact multiple of the word width.
    load(2'd1, 16, 8, 20'h01234);
    run(-1, -1, -1, -1, 1'b0, -1, 19, 10);

    // Single-flop chain, both bit values.
    load(2'd2, 1, 2, 20'h00001);
    run(-1, -1, -1, -1, 1'b0, -1, 4, 3);
    load(2'd2, 1, 2, 20'h00000);
    run(-1, -1, -1, -1, 1'b0, -1, 4, 3);

    // Random chain contents under random backpressure.
    for (int it = 0; it < 4; it++) begin
      load(2'd0, 20, 8, 20'($urandom));
      run(-1, -1, -1, -1, 1'b1, -1, -1, -1);
    end
    for (int it = 0; it < 2; it++) begin
      load(2'd1, 16, 8, 20'($urandom) & 20'h0FFFF);
      run(-1, -1, -1, -1, 1'b1, -1, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
